state_regfile_mp: RTL



---
 rtl/state_rf_pkg.sv | 18 +
 rtl/state_rf_ram.sv | 39 +++
 rtl/state_regfile_mp.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/state_rf_pkg.sv
// Shared widths, field offsets and entry layout for the state register file.
// An entry packs {pos, param_addr, end_flag} with the end flag in bit 0.
package state_rf_pkg;

    localparam int POS_W_DEF = 5;
    localparam int IDX_W_DEF = 12;

    localparam int END_BIT  = 0;
    localparam int ADDR_LSB = 1;
    localparam int POS_LSB  = IDX_W_DEF + 1;

    typedef struct packed {
        logic [POS_W_DEF-1:0] pos;
        logic [IDX_W_DEF-1:0] paramAddr;
        logic                 endFlag;
    } entry_t;

endpackage

// File: rtl/state_rf_ram.sv
// DEPTH x DATA_W storage: one full-width write port, one end-flag set port,
// one registered read port. No reset; the top gates reads of unoccupied entries.
module state_rf_ram
    import state_rf_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = 12,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              upd_i,
    input  logic [IDX_W-1:0]  uaddr_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdataQ;

    // The full write is scheduled after the flag set so a same-index write wins.
    always_ff @(posedge clk) begin
        if (upd_i) begin
            mem[uaddr_i][END_BIT] <= 1'b1;
        end
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdataQ <= mem[raddr_i];
        end
    end

    assign rdata_o = rdataQ;

endmodule

// File: rtl/state_regfile_mp.sv
// Top of the state register file: pointers, occupancy, read arbitration, flags.
// Define STATE_RF_FWD_EN to forward same-cycle write/update data to reads.
module state_regfile_mp
    import state_rf_pkg::*;
#(
    parameter int POS_W  = POS_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DEPTH  = 4096,
    parameter int DATA_W = POS_W + IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [DATA_W-1:0] w_data,
    input  logic              upd_en,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              seq_re,
    input  logic              ran_re,
    input  logic [IDX_W-1:0]  ran_idx,
    output logic              r_valid,
    output logic [IDX_W-1:0]  r_idx,
    output logic [DATA_W-1:0] r_data,
    output logic              r_miss,
    output logic              r_conflict,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [IDX_W-1:0]  wrPtrQ, wrPtrD;
    logic [IDX_W-1:0]  seqPtrQ, seqPtrD;
    logic [CNT_W-1:0]  countQ, countD;
    logic              overflowQ, overflowD;
    logic              rValidQ, rValidD;
    logic [IDX_W-1:0]  rIdxQ, rIdxD;
    logic              rMissQ, rMissD;
    logic              rConflictQ, rConflictD;

    logic              isFull, isEmpty;
    logic              wrAcc, updAcc, seqGo, ranHit, ranGo, rdGo;
    logic [IDX_W-1:0]  rdIdx;
    logic [CNT_W-1:0]  seqInc;
    logic [DATA_W-1:0] ramData, dataOut;

    // All occupancy checks use the pre-edge count; clr suppresses everything else.
    always_comb begin
        isFull  = (countQ == DEPTH_C);
        isEmpty = (countQ == '0);
        wrAcc   = we && !isFull && !clr;
        updAcc  = upd_en && ({1'b0, upd_idx} < countQ) && !clr;
        seqGo   = seq_re && !isEmpty && !clr;
        ranHit  = ({1'b0, ran_idx} < countQ);
        ranGo   = ran_re && !seq_re && ranHit && !clr;
        rdGo    = seqGo || ranGo;
        rdIdx   = seqGo ? seqPtrQ : ran_idx;
        seqInc  = {1'b0, seqPtrQ} + CNT_W'(1);

        wrPtrD     = wrPtrQ;
        seqPtrD    = seqPtrQ;
        countD     = countQ;
        overflowD  = overflowQ;
        rValidD    = 1'b0;
        rIdxD      = rIdxQ;
        rMissD     = 1'b0;
        rConflictD = 1'b0;

        if (clr) begin
            wrPtrD    = '0;
            seqPtrD   = '0;
            countD    = '0;
            overflowD = 1'b0;
            rIdxD     = '0;
        end else begin
            if (wrAcc) begin
                wrPtrD = wrPtrQ + IDX_W'(1);
                countD = countQ + CNT_W'(1);
            end
            if (we && isFull) begin
                overflowD = 1'b1;
            end
            if (seqGo) begin
                seqPtrD = (seqInc >= countQ) ? '0 : seqInc[IDX_W-1:0];
            end
            rValidD    = rdGo;
            rMissD     = ran_re && !seq_re && !ranHit;
            rConflictD = seq_re && ran_re;
            if (rdGo) begin
                rIdxD = rdIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtrQ     <= '0;
            seqPtrQ    <= '0;
            countQ     <= '0;
            overflowQ  <= 1'b0;
            rValidQ    <= 1'b0;
            rIdxQ      <= '0;
            rMissQ     <= 1'b0;
            rConflictQ <= 1'b0;
        end else begin
            wrPtrQ     <= wrPtrD;
            seqPtrQ    <= seqPtrD;
            countQ     <= countD;
            overflowQ  <= overflowD;
            rValidQ    <= rValidD;
            rIdxQ      <= rIdxD;
            rMissQ     <= rMissD;
            rConflictQ <= rConflictD;
        end
    end

    state_rf_ram #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wrAcc),
        .waddr_i (wrPtrQ),
        .wdata_i (w_data),
        .upd_i   (updAcc),
        .uaddr_i (upd_idx),
        .re_i    (rdGo),
        .raddr_i (rdIdx),
        .rdata_o (ramData)
    );

`ifdef STATE_RF_FWD_EN
    logic              fwdWrQ, fwdUpdQ;
    logic [DATA_W-1:0] fwdDataQ;

    // A write to the read index overrides the whole word; an update only sets the flag.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            fwdWrQ   <= 1'b0;
            fwdUpdQ  <= 1'b0;
            fwdDataQ <= '0;
        end else begin
            fwdWrQ   <= wrAcc && rdGo && (wrPtrQ == rdIdx);
            fwdUpdQ  <= updAcc && rdGo && (upd_idx == rdIdx);
            fwdDataQ <= w_data;
        end
    end

    always_comb begin
        dataOut = ramData;
        if (fwdUpdQ) begin
            dataOut[END_BIT] = 1'b1;
        end
        if (fwdWrQ) begin
            dataOut = fwdDataQ;
        end
    end
`else
    assign dataOut = ramData;
`endif

    assign r_valid    = rValidQ;
    assign r_idx      = rIdxQ;
    assign r_data     = rValidQ ? dataOut : '0;
    assign r_miss     = rMissQ;
    assign r_conflict = rConflictQ;
    assign count      = countQ;
    assign full       = isFull;
    assign empty      = isEmpty;
    assign overflow   = overflowQ;

endmodule
